// File: rtl/adc_pdm_pkg.sv
// adc_pdm_pkg: constants shared by the PDM microphone front end.
//   CIC_ORDER      number of integrator/comb stages in the decimator
//   WARMUP_DECIMS  decimated results dropped after reset while the
//                  comb delay lines fill with real history
//   cic_width()    register width that holds the full CIC gain R^N
//                  plus one guard bit for the saturation test
package adc_pdm_pkg;

  localparam int unsigned CIC_ORDER     = 3;
  localparam int unsigned WARMUP_DECIMS = 3;

  function automatic int unsigned cic_width(input int unsigned decim_log2);
    return CIC_ORDER * decim_log2 + 1;
  endfunction

endpackage

// File: rtl/adc_pdm_cic3_decim.sv
// adc_pdm_cic3_decim: 3rd-order CIC decimator for a 1-bit stream.
// Three wrapping integrators run at the sample-strobe rate. Every R
// strobes the third integrator feeds a three-stage registered comb.
// The comb result is saturated and truncated to PCM_BITS, after a
// warm-up of WARMUP_DECIMS discarded results.
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   stb_i        one-cycle sample strobe
//   bit_i        PDM bit, sampled when stb_i is high
//   pcm_o        offset-binary sample, held between pulses
//   pcm_valid_o  one-cycle pulse when pcm_o is updated
module adc_pdm_cic3_decim
  import adc_pdm_pkg::*;
#(
  parameter int unsigned DECIM_LOG2 = 6,
  parameter int unsigned PCM_BITS   = 12
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stb_i,
  input  logic                bit_i,
  output logic [PCM_BITS-1:0] pcm_o,
  output logic                pcm_valid_o
);

  localparam int unsigned W = cic_width(DECIM_LOG2);
  localparam int unsigned R = 1 << DECIM_LOG2;
  localparam logic [DECIM_LOG2-1:0] DEC_LAST = DECIM_LOG2'(R - 1);
  localparam logic [1:0] WARMUP = 2'(WARMUP_DECIMS);

  typedef logic [W-1:0] acc_t;

  // Clamp the one value that reaches bit W-1 (exactly R^3 for an
  // all-ones input) to full scale, then keep the top PCM_BITS bits.
  function automatic logic [PCM_BITS-1:0] sat_trunc(input acc_t v);
    acc_t s;
    s = v[W-1] ? {1'b0, {(W-1){1'b1}}} : v;
    return s[W-2 -: PCM_BITS];
  endfunction

  acc_t                  int1_q, int2_q, int3_q;
  acc_t                  int1_d, int2_d, int3_d;
  logic [DECIM_LOG2-1:0] dec_cnt_q;
  logic                  dec_wrap;

  acc_t                  dly1_q, dly2_q, dly3_q;
  acc_t                  comb1_p1_q, comb2_p2_q, comb3_p3_q;
  logic                  vld_p1_q, vld_p2_q, vld_p3_q;
  logic [1:0]            warm_q;
  logic [PCM_BITS-1:0]   pcm_q;
  logic                  pcm_valid_q;

  always_comb begin
    int1_d   = int1_q + acc_t'(bit_i);
    int2_d   = int2_q + int1_q;
    int3_d   = int3_q + int2_q;
    dec_wrap = stb_i && (dec_cnt_q == DEC_LAST);
  end

  // Integrator section and decimation counter, strobe rate
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      int1_q    <= '0;
      int2_q    <= '0;
      int3_q    <= '0;
      dec_cnt_q <= '0;
    end else if (stb_i) begin
      int1_q    <= int1_d;
      int2_q    <= int2_d;
      int3_q    <= int3_d;
      dec_cnt_q <= dec_cnt_q + 1'b1;
    end
  end

  // Comb delay lines and stage valids; delays move only on decimated data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dly1_q   <= '0;
      dly2_q   <= '0;
      dly3_q   <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p1_q <= dec_wrap;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
      if (dec_wrap) dly1_q <= int3_d;
      if (vld_p1_q) dly2_q <= comb1_p1_q;
      if (vld_p2_q) dly3_q <= comb2_p2_q;
    end
  end

  // Stage p1: first difference, taken in the wrap cycle itself
  // Stage p2: second difference
  // Stage p3: third difference
  always_ff @(posedge clk_i) begin
    if (dec_wrap) comb1_p1_q <= int3_d - dly1_q;
    if (vld_p1_q) comb2_p2_q <= comb1_p1_q - dly2_q;
    if (vld_p2_q) comb3_p3_q <= comb2_p2_q - dly3_q;
  end

  // Output stage: saturate, truncate, drop warm-up results
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      warm_q      <= '0;
      pcm_q       <= '0;
      pcm_valid_q <= 1'b0;
    end else begin
      pcm_valid_q <= 1'b0;
      if (vld_p3_q) begin
        if (warm_q < WARMUP) begin
          warm_q <= warm_q + 2'd1;
        end else begin
          pcm_q       <= sat_trunc(comb3_p3_q);
          pcm_valid_q <= 1'b1;
        end
      end
    end
  end

  assign pcm_o       = pcm_q;
  assign pcm_valid_o = pcm_valid_q;

endmodule

// File: rtl/adc_pdm.sv
// adc_pdm: PDM microphone interface producing offset-binary PCM.
// Generates pdm_clk from the system clock, synchronizes pdm_dat and
// samples it on each falling pdm_clk toggle, then decimates by
// R = 2^DECIM_LOG2 through a 3rd-order CIC.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         run enable; low freezes divider, CIC and pdm_clk level
//   pdm_clk    microphone clock, forced low while en is low
//   pdm_dat    1-bit PDM data, asynchronous to clk
//   pcm        PCM_BITS offset-binary sample, mid-scale 2^(PCM_BITS-1)
//   pcm_valid  one-cycle pulse marking a new pcm value
module adc_pdm
  import adc_pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 20,
  parameter int unsigned DECIM_LOG2 = 6,
  parameter int unsigned PCM_BITS   = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                pdm_clk,
  input  logic                pdm_dat,
  output logic [PCM_BITS-1:0] pcm,
  output logic                pcm_valid
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt_q, div_cnt_d;
  logic       pdm_clk_q, pdm_clk_d;
  logic [1:0] sync_q;
  logic       div_tc;
  logic       sample_stb;

  always_comb begin
    div_tc     = en && (div_cnt_q == DIV_LAST);
    // The 1->0 toggle is the sampling instant.
    sample_stb = div_tc && pdm_clk_q;
    div_cnt_d  = div_cnt_q;
    pdm_clk_d  = pdm_clk_q;
    if (en) div_cnt_d = div_tc ? 8'd0 : div_cnt_q + 8'd1;
    if (div_tc) pdm_clk_d = ~pdm_clk_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      pdm_clk_q <= 1'b0;
      sync_q    <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pdm_clk_q <= pdm_clk_d;
      sync_q    <= {sync_q[0], pdm_dat};
    end
  end

  // Held level is kept internally so en rising resumes mid-period.
  assign pdm_clk = pdm_clk_q & en;

  adc_pdm_cic3_decim #(
    .DECIM_LOG2 (DECIM_LOG2),
    .PCM_BITS   (PCM_BITS)
  ) u_cic (
    .clk_i       (clk),
    .rst_i       (rst),
    .stb_i       (sample_stb),
    .bit_i       (sync_q[1]),
    .pcm_o       (pcm),
    .pcm_valid_o (pcm_valid)
  );

endmodule

// File: doc/adc_pdm.md
ADC_PDM -- requirements
Module: adc_pdm

Interface
REQ-001 The block SHALL expose parameter CLK_DIV, default 20: pdm_clk half-period in clk cycles (legal 4..255).
REQ-002 The block SHALL expose parameter DECIM_LOG2, default 6: decimation ratio R = 2^DECIM_LOG2 (legal 2..7).
REQ-003 The block SHALL expose parameter PCM_BITS, default 12: output sample width (legal 4..3*DECIM_LOG2).
REQ-004 clk  in  1  system clock (40 MHz pixel/audio clock); one clock, no other domains.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  run enable; low freezes all state.
REQ-007 pdm_clk  out  1  clock driven to the PDM microphone.
REQ-008 pdm_dat  in  1  1-bit PDM data from the microphone, asynchronous to clk.
REQ-009 pcm  out  PCM_BITS  unsigned offset-binary sample, same format the PWM DAC consumes (mid-scale = 2^(PCM_BITS-1)).
REQ-010 pcm_valid  out  1  one-clk pulse marking a new pcm value.

Function
REQ-011 Divider counter SHALL count 0..CLK_DIV-1 while en=1 and toggle registered pdm_clk at terminal count, giving period 2*CLK_DIV clk cycles.
REQ-012 pdm_dat SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Sample strobe SHALL fire in the clk cycle where pdm_clk is toggled 1->0; the sample is the synchronizer output in that cycle.
REQ-014 CIC SHALL be 3rd order: three integrators of width W = 3*DECIM_LOG2+1 bits, input 1 -> +1, 0 -> +0, updated only on sample strobe, wrapping modulo 2^W.
REQ-015 Decimation counter SHALL count sample strobes 0..R-1; at the strobe where it wraps (cycle T) the third-integrator value SHALL be captured for the comb section.
REQ-016 Comb section SHALL be three registered difference stages modulo 2^W, one stage per clk cycle (T+1..T+3), each keeping its own delay register updated only on decimated inputs.
REQ-017 Comb result SHALL be saturated to 2^(3*DECIM_LOG2)-1 and pcm SHALL be bits [3*DECIM_LOG2-1 : 3*DECIM_LOG2-PCM_BITS] of it, registered at T+4 with pcm_valid=1 for exactly that cycle.
REQ-018 pcm SHALL hold its value between pulses.
REQ-019 The first 3 decimated results after reset SHALL be discarded (warm-up): pcm not updated, pcm_valid not asserted.
REQ-020 When en=0 all counters, integrators, combs and pdm_clk level SHALL hold; pdm_clk SHALL be forced low on the output; an in-flight comb pipeline SHALL still complete and pulse pcm_valid.
REQ-021 en rising SHALL resume from held state with no extra or missing strobe.

Reset
REQ-022 On rst=1: pdm_clk=0, pcm=0, pcm_valid=0, synchronizer, all counters, integrators, comb delays and pipeline valids = 0, warm-up count restarted; effect immediate (asynchronous), release taking effect on next clk edge.
REQ-023 Reset asserted mid-pipeline SHALL cancel any pending pcm_valid.

Structure
REQ-024 No shared package is required; W and R SHALL be local constants derived from parameters.
REQ-025 One sub-module, cic3_decim (integrators+combs+saturation), is natural; divider and synchronizer stay in adc_pdm.

Verification
REQ-026 Defaults, en=1: pdm_clk period = 40 clk (1 MHz), pcm_valid period = 2560 clk (15.625 kHz) after warm-up.
REQ-027 pdm_dat held 1 -> after warm-up pcm = 4095 (saturation path), pcm_valid pulses of width 1.
REQ-028 pdm_dat held 0 -> pcm = 0; first three decimations produce no pcm_valid.
REQ-029 pdm_dat alternating 1,0 per pdm_clk -> pcm = 2048 (0x800) steady.
REQ-030 en low for 1000 clk mid-frame -> pdm_clk low, no strobes, then next pcm_valid arrives exactly 1000 clk later than without the pause, value unchanged.
REQ-031 rst pulsed 2 cycles after a decimation wrap -> no pcm_valid from that pipeline, pcm=0, warm-up restarts.
